// File: rtl/uart_char_receiver.sv
// ---------------------------------------------------------------------------
// uart_char_receiver
//   8N1 serial receiver feeding a small character FIFO. Decoded bytes queue up
//   so a busy consumer never loses a character; the head byte is held on
//   o_char_out until the consumer acknowledges it.
//
// Ports
//   clock          system clock, all logic on posedge
//   reset          synchronous, active-high
//   i_rx_in        asynchronous serial line, idle high
//   i_char_ack     pop the head character (ignored while empty)
//   o_char_out     FIFO head, IDLE_CHAR while empty
//   o_char_valid   FIFO not empty
//   o_frame_err    one-cycle pulse: stop bit sampled low
//   o_overflow     sticky: a byte was dropped because the FIFO was full
//   o_fifo_count   number of stored characters
// ---------------------------------------------------------------------------
module uart_char_receiver #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [7:0]  IDLE_CHAR    = 8'h00
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             i_rx_in,
  input  logic                             i_char_ack,
  output logic [7:0]                       o_char_out,
  output logic                             o_char_valid,
  output logic                             o_frame_err,
  output logic                             o_overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_fifo_count
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FCNT_W-1:0] FULL_COUNT = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // Synchronizer and receiver state
  logic             r_sync_meta;
  logic             r_rx_s;
  rx_state_t        r_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_frame_err;

  rx_state_t        w_state_nxt;
  logic [CNT_W-1:0] w_clk_cnt_nxt;
  logic [2:0]       w_bit_cnt_nxt;
  logic [7:0]       w_shift_nxt;
  logic             w_push_req;
  logic             w_frame_err_nxt;

  // FIFO state
  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [FCNT_W-1:0] r_count;
  logic              r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // -------------------------------------------------------------------------
  // Input synchronizer: both flops reset to the idle (high) line level so a
  // reset never looks like a start bit.
  // -------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking assignments so all flops
  // update together from the values present before the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync_meta <= 1'b1;
      r_rx_s      <= 1'b1;
    end else begin
      r_sync_meta <= i_rx_in;
      r_rx_s      <= r_sync_meta;
    end
  end

  // -------------------------------------------------------------------------
  // RX FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= RX_IDLE;
      r_clk_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clk_cnt   <= w_clk_cnt_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // RX FSM: next-state logic. The start bit is re-checked at its midpoint;
  // every later sample lands one full bit period further on, i.e. mid-bit.
  // -------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_clk_cnt_nxt   = r_clk_cnt + CNT_W'(1);
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_push_req      = 1'b0;
    w_frame_err_nxt = 1'b0;

    case (r_state)
      RX_IDLE: begin
        w_clk_cnt_nxt = '0;
        if (!r_rx_s) begin
          w_state_nxt = RX_START;
        end
      end

      RX_START: begin
        if (r_clk_cnt == HALF_LAST) begin
          w_clk_cnt_nxt = '0;
          w_bit_cnt_nxt = '0;
          // A line that is high again at mid-start was only a glitch.
          w_state_nxt   = r_rx_s ? RX_IDLE : RX_DATA;
        end
      end

      RX_DATA: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_clk_cnt_nxt = '0;
          w_shift_nxt   = {r_rx_s, r_shift[7:1]};  // LSB arrives first
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = RX_STOP;
          end
        end
      end

      RX_STOP: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_clk_cnt_nxt = '0;
          if (r_rx_s) begin
            w_push_req  = 1'b1;
            w_state_nxt = RX_IDLE;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = RX_WAIT_HIGH;
          end
        end
      end

      RX_WAIT_HIGH: begin
        // A line still low after a bad stop bit is not a new start bit.
        w_clk_cnt_nxt = '0;
        if (r_rx_s) begin
          w_state_nxt = RX_IDLE;
        end
      end

      default: begin
        w_clk_cnt_nxt = '0;
        w_state_nxt   = RX_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Character FIFO. A push into a full FIFO still succeeds when the consumer
  // frees a slot in the same cycle; a pop on an empty FIFO is ignored.
  // -------------------------------------------------------------------------
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_COUNT);
  assign w_pop   = i_char_ack && !w_empty;
  assign w_push  = w_push_req && (!w_full || w_pop);
  assign w_drop  = w_push_req && w_full && !w_pop;

  // NOTE: the storage array carries no reset; r_count alone decides which
  // entries are meaningful, so stale contents are never observed.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + FCNT_W'(1);
        2'b01:   r_count <= r_count - FCNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Outputs are taken straight from registers (head read through the pointer).
  assign o_char_out   = w_empty ? IDLE_CHAR : r_mem[r_rd_ptr];
  assign o_char_valid = !w_empty;
  assign o_frame_err  = r_frame_err;
  assign o_overflow   = r_overflow;
  assign o_fifo_count = r_count;

endmodule
